// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC sequencing, icache handshake, stall hold and redirect squash.
// Zero-latency combinational outputs; icache_ready_i low holds the address, stall_i parks the instruction in HOLD.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic [31:0] icache_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_o,
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] redir_pc;
  logic [31:0] pc_plus;

  assign redir_pc      = redirect_pc_i & ~32'h3;
  assign pc_plus       = pc + 32'd4;
  assign pc_o          = pc;
  assign pc_plus_o     = pc_plus;
  assign icache_addr_o = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_pc    <= pend_pc_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_pc_nxt    = pend_pc;
    hold_instr_nxt = hold_instr;
    icache_req_o   = 1'b0;
    instr_o        = NOP_INSTR;
    instr_valid_o  = 1'b0;

    case (state)
      FETCH: begin
        icache_req_o = 1'b1;
        if (redirect_valid_i) begin
          // A redirect squashes whatever returns; an unanswered request must still drain.
          if (icache_ready_i) begin
            pc_nxt = redir_pc;
          end else begin
            pend_pc_nxt = redir_pc;
            state_nxt   = DISCARD;
          end
        end else if (icache_ready_i) begin
          instr_o       = icache_rdata_i;
          instr_valid_o = 1'b1;
          if (stall_i) begin
            hold_instr_nxt = icache_rdata_i;
            state_nxt      = HOLD;
          end else begin
            pc_nxt = pc_plus;
          end
        end
      end

      HOLD: begin
        if (redirect_valid_i) begin
          pc_nxt    = redir_pc;
          state_nxt = FETCH;
        end else begin
          instr_o       = hold_instr;
          instr_valid_o = 1'b1;
          if (!stall_i) begin
            pc_nxt    = pc_plus;
            state_nxt = FETCH;
          end
        end
      end

      DISCARD: begin
        icache_req_o = 1'b1;
        if (redirect_valid_i) pend_pc_nxt = redir_pc;
        if (icache_ready_i) begin
          pc_nxt    = redirect_valid_i ? redir_pc : pend_pc;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

endmodule
